hazard_ctrl: RTL and testbench

Parametrised hazard control unit for the Otter pipeline; successor to the single-cycle hazard unit. Keeps combinational MEM/WB forwarding-select generation. Adds:
- a configurable multi-cycle load-use stall,
- a configurable multi-cycle flush after redirect,
- a per-register scoreboard for an out-of-band multi-cycle execution unit (mul/div), with an outstanding-operation limit.

Sits between the DEC/EX/MEM/WB pipeline registers and the PC/IF/DEC stall and flush controls.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_scoreboard.sv | 74 +++++++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the Otter hazard control unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fsel_t;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    // Width of a down-counter that must hold param-1, never narrower than 1 bit.
    function automatic int unsigned cnt_w(input int unsigned p);
        return $clog2((p > 2) ? p : 2);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-destination scoreboard for the out-of-band multi-cycle unit (mul/div).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned MC_DEPTH = 2,
    localparam int unsigned REG_W   = $clog2(NREGS),
    localparam int unsigned CNT_W   = $clog2(MC_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mc_start,
    input  logic [REG_W-1:0] i_mc_start_rd,
    input  logic             i_mc_done,
    input  logic [REG_W-1:0] i_mc_done_rd,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic [REG_W-1:0] i_rd,
    output logic             o_rs1_pend,
    output logic             o_rs2_pend,
    output logic             o_rd_pend,
    output logic             o_busy
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_pending_nxt;
    logic [CNT_W-1:0] r_out_cnt;
    logic [CNT_W-1:0] w_out_cnt_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_start_ok;

    assign w_full  = (r_out_cnt == CNT_W'(MC_DEPTH));
    assign w_empty = (r_out_cnt == '0);

    // A start at the limit is only accepted when a done frees a slot that cycle.
    assign w_start_ok = i_mc_start & (~w_full | i_mc_done);

    always_comb begin
        w_out_cnt_nxt = r_out_cnt;
        unique case ({i_mc_start, i_mc_done})
            2'b10:   if (!w_full)  w_out_cnt_nxt = r_out_cnt + CNT_W'(1);
            2'b01:   if (!w_empty) w_out_cnt_nxt = r_out_cnt - CNT_W'(1);
            default: w_out_cnt_nxt = r_out_cnt;
        endcase
    end

    // Clear first so a same-register set in the same cycle wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_mc_done) begin
            w_pending_nxt[i_mc_done_rd] = 1'b0;
        end
        if (w_start_ok && (i_mc_start_rd != '0)) begin
            w_pending_nxt[i_mc_start_rd] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
            r_out_cnt <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_out_cnt <= w_out_cnt_nxt;
        end
    end

    assign o_rs1_pend = r_pending[i_rs1];
    assign o_rs2_pend = r_pending[i_rs2];
    assign o_rd_pend  = r_pending[i_rd];
    assign o_busy     = w_full;

endmodule

// File: rtl/hazard_ctrl.sv
// Otter hazard control: MEM/WB forwarding selects, multi-cycle load-use stall,
// multi-cycle redirect flush and multi-cycle-unit scoreboard interlock.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NREGS        = 32,
    parameter int unsigned LOAD_STALL   = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MC_DEPTH     = 2,
    localparam int unsigned REG_W       = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       opcode,
    input  logic [REG_W-1:0] DEC_rs1,
    input  logic [REG_W-1:0] DEC_rs2,
    input  logic [REG_W-1:0] DEC_rd,
    input  logic             DEC_rs1_used,
    input  logic             DEC_rs2_used,
    input  logic             DEC_rd_used,
    input  logic             DEC_mc,
    input  logic [REG_W-1:0] EX_rs1,
    input  logic [REG_W-1:0] EX_rs2,
    input  logic [REG_W-1:0] EX_rd,
    input  logic             EX_rs1_used,
    input  logic             EX_rs2_used,
    input  logic [REG_W-1:0] MEM_rd,
    input  logic [REG_W-1:0] WB_rd,
    input  logic             MEM_REGWE,
    input  logic             WB_REGWE,
    input  logic [1:0]       PC_src,
    input  logic             mc_start,
    input  logic [REG_W-1:0] mc_start_rd,
    input  logic             mc_done,
    input  logic [REG_W-1:0] mc_done_rd,
    output logic [1:0]       fsel1,
    output logic [1:0]       fsel2,
    output logic             STALL,
    output logic             FLUSH,
    output logic             mc_busy
);

    localparam int unsigned LD_W = cnt_w(LOAD_STALL);
    localparam int unsigned FL_W = cnt_w(FLUSH_CYCLES);
    localparam logic [LD_W-1:0] LD_INIT = LD_W'(LOAD_STALL - 1);
    localparam logic [FL_W-1:0] FL_INIT = FL_W'(FLUSH_CYCLES - 1);

    function automatic fsel_t fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             used,
        input logic [REG_W-1:0] mem_rd,
        input logic             mem_we,
        input logic [REG_W-1:0] wb_rd,
        input logic             wb_we
    );
        if (mem_we && used && (mem_rd == rs) && (mem_rd != '0)) begin
            return FWD_MEM;
        end else if (wb_we && used && (wb_rd == rs) && (wb_rd != '0)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

    fsel_t           w_fsel1;
    fsel_t           w_fsel2;
    logic            w_ld_hit;
    logic            w_redirect;
    logic            w_flush;
    logic            w_stall;
    logic            w_sb_hit;
    logic            w_rs1_pend;
    logic            w_rs2_pend;
    logic            w_rd_pend;
    logic            w_busy;
    logic [LD_W-1:0] r_ld_cnt;
    logic [LD_W-1:0] w_ld_cnt_nxt;
    logic [FL_W-1:0] r_fl_cnt;
    logic [FL_W-1:0] w_fl_cnt_nxt;

    assign w_fsel1 = fwd_sel(EX_rs1, EX_rs1_used, MEM_rd, MEM_REGWE, WB_rd, WB_REGWE);
    assign w_fsel2 = fwd_sel(EX_rs2, EX_rs2_used, MEM_rd, MEM_REGWE, WB_rd, WB_REGWE);

    assign w_ld_hit = (opcode == OP_LOAD) && (EX_rd != '0) &&
                      ((DEC_rs1_used && (DEC_rs1 == EX_rd)) ||
                       (DEC_rs2_used && (DEC_rs2 == EX_rd)));

    assign w_redirect = (PC_src != 2'b00);

    hazard_scoreboard #(
        .NREGS    (NREGS),
        .MC_DEPTH (MC_DEPTH)
    ) u_scoreboard (
        .i_clk         (CLK),
        .i_rst         (RST),
        .i_mc_start    (mc_start),
        .i_mc_start_rd (mc_start_rd),
        .i_mc_done     (mc_done),
        .i_mc_done_rd  (mc_done_rd),
        .i_rs1         (DEC_rs1),
        .i_rs2         (DEC_rs2),
        .i_rd          (DEC_rd),
        .o_rs1_pend    (w_rs1_pend),
        .o_rs2_pend    (w_rs2_pend),
        .o_rd_pend     (w_rd_pend),
        .o_busy        (w_busy)
    );

    assign w_sb_hit = (DEC_rs1_used & w_rs1_pend) | (DEC_rs2_used & w_rs2_pend) |
                      (DEC_rd_used & w_rd_pend) | (DEC_mc & w_busy);

    always_comb begin
        w_ld_cnt_nxt = r_ld_cnt;
        if (w_redirect) begin
            w_ld_cnt_nxt = '0;
        end else if (r_ld_cnt != '0) begin
            w_ld_cnt_nxt = r_ld_cnt - LD_W'(1);
        end else if (w_ld_hit) begin
            w_ld_cnt_nxt = LD_INIT;
        end
    end

    // A redirect while a flush is still draining restarts the full window.
    always_comb begin
        w_fl_cnt_nxt = r_fl_cnt;
        if (w_redirect) begin
            w_fl_cnt_nxt = FL_INIT;
        end else if (r_fl_cnt != '0) begin
            w_fl_cnt_nxt = r_fl_cnt - FL_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ld_cnt <= '0;
            r_fl_cnt <= '0;
        end else begin
            r_ld_cnt <= w_ld_cnt_nxt;
            r_fl_cnt <= w_fl_cnt_nxt;
        end
    end

    assign w_flush = w_redirect | (r_fl_cnt != '0);
    assign w_stall = (w_ld_hit | (r_ld_cnt != '0) | w_sb_hit) & ~w_flush;

    // Outputs are forced quiet for the whole reset window, not just after the edge.
    assign fsel1   = RST ? FWD_NONE : w_fsel1;
    assign fsel2   = RST ? FWD_NONE : w_fsel2;
    assign STALL   = ~RST & w_stall;
    assign FLUSH   = ~RST & w_flush;
    assign mc_busy = ~RST & w_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with LOAD_STALL=2, FLUSH_CYCLES=2, MC_DEPTH=2.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned NREGS = 32;
    localparam int unsigned REG_W = 5;

    logic             CLK = 1'b0;
    logic             RST;
    logic [6:0]       opcode;
    logic [REG_W-1:0] DEC_rs1, DEC_rs2, DEC_rd;
    logic             DEC_rs1_used, DEC_rs2_used, DEC_rd_used, DEC_mc;
    logic [REG_W-1:0] EX_rs1, EX_rs2, EX_rd;
    logic             EX_rs1_used, EX_rs2_used;
    logic [REG_W-1:0] MEM_rd, WB_rd;
    logic             MEM_REGWE, WB_REGWE;
    logic [1:0]       PC_src;
    logic             mc_start, mc_done;
    logic [REG_W-1:0] mc_start_rd, mc_done_rd;
    logic [1:0]       fsel1, fsel2;
    logic             STALL, FLUSH, mc_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(
        .NREGS        (NREGS),
        .LOAD_STALL   (2),
        .FLUSH_CYCLES (2),
        .MC_DEPTH     (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .opcode       (opcode),
        .DEC_rs1      (DEC_rs1),
        .DEC_rs2      (DEC_rs2),
        .DEC_rd       (DEC_rd),
        .DEC_rs1_used (DEC_rs1_used),
        .DEC_rs2_used (DEC_rs2_used),
        .DEC_rd_used  (DEC_rd_used),
        .DEC_mc       (DEC_mc),
        .EX_rs1       (EX_rs1),
        .EX_rs2       (EX_rs2),
        .EX_rd        (EX_rd),
        .EX_rs1_used  (EX_rs1_used),
        .EX_rs2_used  (EX_rs2_used),
        .MEM_rd       (MEM_rd),
        .WB_rd        (WB_rd),
        .MEM_REGWE    (MEM_REGWE),
        .WB_REGWE     (WB_REGWE),
        .PC_src       (PC_src),
        .mc_start     (mc_start),
        .mc_start_rd  (mc_start_rd),
        .mc_done      (mc_done),
        .mc_done_rd   (mc_done_rd),
        .fsel1        (fsel1),
        .fsel2        (fsel2),
        .STALL        (STALL),
        .FLUSH        (FLUSH),
        .mc_busy      (mc_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        opcode = 7'd0;
        DEC_rs1 = '0; DEC_rs2 = '0; DEC_rd = '0;
        DEC_rs1_used = 0; DEC_rs2_used = 0; DEC_rd_used = 0; DEC_mc = 0;
        EX_rs1 = '0; EX_rs2 = '0; EX_rd = '0;
        EX_rs1_used = 0; EX_rs2_used = 0;
        MEM_rd = '0; WB_rd = '0; MEM_REGWE = 0; WB_REGWE = 0;
        PC_src = 2'b00;
        mc_start = 0; mc_start_rd = '0; mc_done = 0; mc_done_rd = '0;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        EX_rs1 = 5; EX_rs1_used = 1; MEM_rd = 5; MEM_REGWE = 1; PC_src = 2'b01;
        #2;
        check("rst_fsel1", 32'(fsel1), 0);
        check("rst_stall", 32'(STALL), 0);
        check("rst_flush", 32'(FLUSH), 0);
        check("rst_busy", 32'(mc_busy), 0);
        PC_src = 2'b00;
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;

        // Forwarding
        WB_rd = 5; WB_REGWE = 1; EX_rs2 = 5; EX_rs2_used = 1;
        #1;
        check("fwd1_mem_prio", 32'(fsel1), 32'(FWD_MEM));
        check("fwd2_mem_prio", 32'(fsel2), 32'(FWD_MEM));
        MEM_REGWE = 0;
        #1;
        check("fwd1_wb", 32'(fsel1), 32'(FWD_WB));
        EX_rs2_used = 0;
        #1;
        check("fwd2_unused", 32'(fsel2), 32'(FWD_NONE));
        MEM_REGWE = 1; MEM_rd = 0; EX_rs1 = 0; WB_rd = 0;
        #1;
        check("fwd1_x0", 32'(fsel1), 32'(FWD_NONE));
        check("fwd_no_stall", 32'(STALL), 0);

        // Load-use, two bubble cycles
        idle();
        tick();
        opcode = OP_LOAD; EX_rd = 7; DEC_rs2 = 7; DEC_rs2_used = 1;
        #1;
        check("ld_c0_stall", 32'(STALL), 1);
        check("ld_c0_flush", 32'(FLUSH), 0);
        tick();
        opcode = 7'd0;
        #1;
        check("ld_c1_stall", 32'(STALL), 1);
        tick();
        check("ld_c2_stall", 32'(STALL), 0);
        opcode = OP_LOAD; EX_rd = 0; DEC_rs2 = 0;
        #1;
        check("ld_x0", 32'(STALL), 0);
        idle();
        tick();

        // Scoreboard RAW / set-wins / WAW
        mc_start = 1; mc_start_rd = 9;
        tick();
        mc_start = 0; DEC_rs1 = 9; DEC_rs1_used = 1;
        #1;
        check("sb_raw", 32'(STALL), 1);
        mc_start = 1; mc_start_rd = 9; mc_done = 1; mc_done_rd = 9;
        tick();
        mc_start = 0; mc_done = 0;
        #1;
        check("sb_set_wins", 32'(STALL), 1);
        mc_done = 1; mc_done_rd = 9;
        #1;
        check("sb_done_cycle", 32'(STALL), 1);
        tick();
        mc_done = 0;
        #1;
        check("sb_cleared", 32'(STALL), 0);
        DEC_rs1_used = 0;
        mc_start = 1; mc_start_rd = 9;
        tick();
        mc_start = 0; DEC_rd = 9; DEC_rd_used = 1;
        #1;
        check("sb_waw", 32'(STALL), 1);
        mc_done = 1; mc_done_rd = 9;
        tick();
        mc_done = 0;
        #1;
        check("sb_waw_clr", 32'(STALL), 0);
        idle();

        // Outstanding limit
        mc_start = 1; mc_start_rd = 3;
        tick();
        mc_start_rd = 4;
        tick();
        mc_start = 0; DEC_mc = 1;
        #1;
        check("busy_full", 32'(mc_busy), 1);
        check("busy_stall", 32'(STALL), 1);
        mc_done = 1; mc_done_rd = 3;
        #1;
        check("busy_done_cycle", 32'(STALL), 1);
        tick();
        mc_done = 0;
        #1;
        check("busy_freed", 32'(mc_busy), 0);
        check("busy_unstall", 32'(STALL), 0);
        DEC_mc = 0;
        mc_done = 1; mc_done_rd = 4;
        tick();
        mc_done_rd = 5;
        tick();
        mc_done = 0; mc_start = 1; mc_start_rd = 10;
        tick();
        mc_start = 0;
        #1;
        check("sat_low", 32'(mc_busy), 0);
        mc_start = 1; mc_start_rd = 11;
        tick();
        mc_start = 0;
        #1;
        check("sat_full", 32'(mc_busy), 1);
        mc_start = 1; mc_start_rd = 12;
        tick();
        mc_start = 0; mc_done = 1; mc_done_rd = 10;
        tick();
        mc_done = 0;
        #1;
        check("sat_high", 32'(mc_busy), 0);
        mc_done = 1; mc_done_rd = 11;
        tick();
        idle();

        // Redirect during load-use stall, then reload
        opcode = OP_LOAD; EX_rd = 7; DEC_rs2 = 7; DEC_rs2_used = 1;
        #1;
        check("fl_pre_stall", 32'(STALL), 1);
        tick();
        opcode = 7'd0; PC_src = 2'b01;
        #1;
        check("fl_c0_flush", 32'(FLUSH), 1);
        check("fl_c0_stall", 32'(STALL), 0);
        tick();
        PC_src = 2'b00;
        #1;
        check("fl_c1_flush", 32'(FLUSH), 1);
        check("fl_c1_stall", 32'(STALL), 0);
        tick();
        check("fl_c2_flush", 32'(FLUSH), 0);
        check("fl_c2_stall", 32'(STALL), 0);
        PC_src = 2'b10;
        tick();
        PC_src = 2'b11;
        tick();
        PC_src = 2'b00;
        #1;
        check("fl_reload", 32'(FLUSH), 1);
        tick();
        check("fl_reload_end", 32'(FLUSH), 0);
        idle();

        // Reset mid-flush with pending[9]
        mc_start = 1; mc_start_rd = 9;
        tick();
        mc_start = 0; PC_src = 2'b01;
        tick();
        PC_src = 2'b00; DEC_rs1 = 9; DEC_rs1_used = 1;
        EX_rs1 = 5; EX_rs1_used = 1; MEM_rd = 5; MEM_REGWE = 1;
        #1;
        check("mid_flush", 32'(FLUSH), 1);
        RST = 1'b1;
        #1;
        check("rst_mid_fsel1", 32'(fsel1), 0);
        check("rst_mid_stall", 32'(STALL), 0);
        check("rst_mid_flush", 32'(FLUSH), 0);
        check("rst_mid_busy", 32'(mc_busy), 0);
        #1 RST = 1'b0;
        #1;
        check("post_rst_fsel1", 32'(fsel1), 32'(FWD_MEM));
        tick();
        check("post_rst_stall", 32'(STALL), 0);
        check("post_rst_flush", 32'(FLUSH), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
